// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_WR write / NUM_RD combinational read ports, optional zero entry and write bypass.
// A DEPTH-cycle clear sweep runs after reset or clr. ready drops for the sweep, and the file ignores writes and reads 0 during it.
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    ready,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_cnt, w_cnt_nxt;
  logic              w_sweep_we;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [NUM_WR-1:0] w_wr_ok;
  logic [AW-1:0]     w_wa [NUM_WR];
  logic [AW-1:0]     w_ra [NUM_RD];

  // Address is backed by storage and is not the hardwired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sweep_we  = 1'b0;
    case (r_state)
      S_INIT: begin
        if (clr) begin
          w_cnt_nxt = '0;
        end else begin
          w_sweep_we = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = S_READY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_READY: begin
        if (clr) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign ready = (r_state == S_READY);

  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      w_wa[p]    = wr_addr[p*AW +: AW];
      w_wr_ok[p] = (r_state == S_READY) && wr_en[p] && addr_ok(w_wa[p]);
    end
  end

  // Later loop iterations override earlier ones, so the highest port wins a collision.
  always_ff @(posedge clk) begin
    if (w_sweep_we)
      r_mem[r_cnt] <= '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (w_wr_ok[p])
        r_mem[w_wa[p]] <= wr_data[p*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      w_ra[r] = rd_addr[r*AW +: AW];
      if ((r_state == S_READY) && addr_ok(w_ra[r])) begin
        rd_data[r*WIDTH +: WIDTH] = r_mem[w_ra[r]];
        if (BYPASS) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (w_wr_ok[p] && (w_wa[p] == w_ra[r]))
              rd_data[r*WIDTH +: WIDTH] = wr_data[p*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

endmodule
